// File: rtl/maxpool_buffer_writer_pkg.sv
// Shared buffer geometry and writer state encoding for the max-pool -> FC handoff.
package maxpool_buffer_writer_pkg;

  // Buffer geometry; the FC read-side counter uses the same constants.
  localparam int NUM_MAX_RESULTS = 507;
  localparam int MAX_ADDR_WIDTH  = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    FULL  = 2'd3
  } wr_state_t;

endpackage

// File: rtl/maxpool_write_addr_gen.sv
// Fill counter for the max-pool buffer writer: clear, increment, terminal flag.
module maxpool_write_addr_gen #(
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_ENTRIES = 507
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_ENTRIES - 1);
  localparam logic [ADDR_WIDTH-1:0] TERM_CNT = ADDR_WIDTH'(NUM_ENTRIES);

  // Count accepted beats; stops at NUM_ENTRIES so it reads as "complete" while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != TERM_CNT)) begin
      count <= count + 1'b1;
    end
  end

  // Next accepted beat is the final one of the image.
  assign last = (count == LAST_IDX);

endmodule

// File: rtl/maxpool_buffer_writer.sv
// Write-side controller for the max-pool result buffer feeding the FC stage.
// Streams pooled activations into addresses 0..NUM_ENTRIES-1, then hands the
// buffer to the reader and holds it until the reader lets it go.
module maxpool_buffer_writer
  import maxpool_buffer_writer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = MAX_ADDR_WIDTH,
  parameter int NUM_ENTRIES = NUM_MAX_RESULTS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  done,
  output logic                  full,
  input  logic                  buf_release,  // reader finished with the buffer
  output logic [ADDR_WIDTH-1:0] fill_count
);

  wr_state_t state_q, state_d;
  logic      accept;
  logic      cnt_clear;
  logic      cnt_last;

  // Ready depends on state only, so the producer never sees a valid->ready loop.
  assign in_ready = (state_q == FILL);
  assign accept   = in_valid && in_ready;
  assign full     = (state_q == FULL);

  maxpool_write_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .inc   (accept),
    .count (fill_count),
    .last  (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and fill-counter clear on every entry to FILL.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FILL;
          cnt_clear = 1'b1;
        end
      end
      FILL: begin
        if (accept && cnt_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = FULL;
      end
      FULL: begin
        if (buf_release) begin
          if (start) begin
            state_d   = FILL;
            cnt_clear = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port: one-cycle registered copy of each accepted beat; address and data hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr  <= fill_count;
        mem_wdata <= in_data;
      end
    end
  end

  // Done pulses in the first FULL cycle, i.e. the cycle after FLUSH, once the last write has committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state_q == FLUSH);
    end
  end

endmodule
